// File: rtl/mips_core_pkg.sv
// Shared core types: ALU control codes, branch outcome and datapath width.
package mips_core_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ALU_CTL_W  = 5;

  typedef enum logic [ALU_CTL_W-1:0] {
    NOP       = 5'd0,
    ADD       = 5'd1,
    ADDU      = 5'd2,
    SUB       = 5'd3,
    SUBU      = 5'd4,
    AND       = 5'd5,
    OR        = 5'd6,
    XOR       = 5'd7,
    NOR       = 5'd8,
    SLL       = 5'd9,
    SRL       = 5'd10,
    SRA       = 5'd11,
    SLT       = 5'd12,
    SLTU      = 5'd13,
    MTC0_NOOP = 5'd14,
    MTC0_PASS = 5'd15,
    MTC0_FAIL = 5'd16,
    MTC0_DONE = 5'd17,
    BA        = 5'd18,
    BEQ       = 5'd19,
    BNE       = 5'd20,
    BLEZ      = 5'd21,
    BGTZ      = 5'd22,
    BGEZ      = 5'd23,
    BLTZ      = 5'd24
  } alu_ctl_t;

  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } branch_outcome_t;

  // True for the control codes that can update the test-completion flags
  function automatic logic is_mtc0_report(input alu_ctl_t ctl);
    return (ctl == MTC0_PASS) || (ctl == MTC0_FAIL) || (ctl == MTC0_DONE);
  endfunction

endpackage

// File: rtl/mips_alu_ifc.sv
// ALU request, ALU response and pass/done flag bundles.
interface alu_input_ifc #(
  parameter int unsigned DATA_WIDTH = mips_core_pkg::DATA_WIDTH
);
  logic                           valid;
  mips_core_pkg::alu_ctl_t        alu_ctl;
  logic [DATA_WIDTH-1:0]          op1;
  logic [DATA_WIDTH-1:0]          op2;

  modport in  (input  valid, alu_ctl, op1, op2);
  modport out (output valid, alu_ctl, op1, op2);
endinterface

interface alu_output_ifc #(
  parameter int unsigned DATA_WIDTH = mips_core_pkg::DATA_WIDTH
);
  logic                           valid;
  logic [DATA_WIDTH-1:0]          result;
  mips_core_pkg::branch_outcome_t branch_outcome;

  modport in  (input  valid, result, branch_outcome);
  modport out (output valid, result, branch_outcome);
endinterface

interface pass_done_ifc;
  logic done;
  logic pass;

  modport in  (input  done, pass);
  modport out (output done, pass);
endinterface

// File: rtl/mips_alu_pass_done_reg.sv
// Sticky test-completion flags: the first reported outcome wins until reset.
module mips_alu_pass_done_reg
  import mips_core_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     valid,
  input  alu_ctl_t alu_ctl,
  output logic     done,
  output logic     pass
);

  // Latch the first valid MTC0 report; once done is set the flags freeze
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
      pass <= 1'b0;
    end else if (valid && !done && is_mtc0_report(alu_ctl)) begin
      done <= 1'b1;
      if (alu_ctl == MTC0_PASS) begin
        pass <= 1'b1;
      end else if (alu_ctl == MTC0_FAIL) begin
        pass <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mips_alu.sv
// EX-stage ALU: same-cycle arithmetic/logic/branch resolution plus sticky pass/done flags.
module mips_alu #(
  parameter int unsigned DATA_WIDTH = mips_core_pkg::DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_input_ifc.in         in,
  alu_output_ifc.out       out,
  pass_done_ifc.out        pass_done
);

  localparam int unsigned SHAMT_W = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0]          result_c;
  mips_core_pkg::branch_outcome_t branch_c;
  logic [SHAMT_W-1:0]             shamt;
  logic signed [DATA_WIDTH-1:0]   op1_s;
  logic signed [DATA_WIDTH-1:0]   op2_s;
  logic signed [DATA_WIDTH-1:0]   sra_c;
  logic                           op1_neg;
  logic                           op1_zero;
  logic                           done;
  logic                           pass;

  assign shamt    = in.op1[SHAMT_W-1:0];
  assign op1_s    = in.op1;
  assign op2_s    = in.op2;
  assign op1_neg  = in.op1[DATA_WIDTH-1];
  assign op1_zero = (in.op1 == '0);

  // Datapath: result and branch decision from the current request
  always_comb begin
    result_c = '0;
    branch_c = mips_core_pkg::NOT_TAKEN;
    sra_c    = op2_s >>> shamt;
    if (in.valid) begin
      unique case (in.alu_ctl)
        mips_core_pkg::ADD,
        mips_core_pkg::ADDU: result_c = in.op1 + in.op2;
        mips_core_pkg::SUB,
        mips_core_pkg::SUBU: result_c = in.op1 - in.op2;
        mips_core_pkg::AND:  result_c = in.op1 & in.op2;
        mips_core_pkg::OR:   result_c = in.op1 | in.op2;
        mips_core_pkg::XOR:  result_c = in.op1 ^ in.op2;
        mips_core_pkg::NOR:  result_c = ~(in.op1 | in.op2);
        mips_core_pkg::SLL:  result_c = in.op2 << shamt;
        mips_core_pkg::SRL:  result_c = in.op2 >> shamt;
        mips_core_pkg::SRA:  result_c = sra_c;
        mips_core_pkg::SLT:  result_c = DATA_WIDTH'(op1_s < op2_s);
        mips_core_pkg::SLTU: result_c = DATA_WIDTH'(in.op1 < in.op2);
        mips_core_pkg::BA:   branch_c = mips_core_pkg::TAKEN;
        mips_core_pkg::BEQ:  if (in.op1 == in.op2) branch_c = mips_core_pkg::TAKEN;
        mips_core_pkg::BNE:  if (in.op1 != in.op2) branch_c = mips_core_pkg::TAKEN;
        mips_core_pkg::BLEZ: if (op1_neg || op1_zero) branch_c = mips_core_pkg::TAKEN;
        mips_core_pkg::BGTZ: if (!op1_neg && !op1_zero) branch_c = mips_core_pkg::TAKEN;
        mips_core_pkg::BGEZ: if (!op1_neg) branch_c = mips_core_pkg::TAKEN;
        mips_core_pkg::BLTZ: if (op1_neg) branch_c = mips_core_pkg::TAKEN;
        default: begin
          result_c = '0;
          branch_c = mips_core_pkg::NOT_TAKEN;
        end
      endcase
    end
  end

  assign out.valid          = in.valid;
  assign out.result         = result_c;
  assign out.branch_outcome = branch_c;

  mips_alu_pass_done_reg u_pass_done_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (in.valid),
    .alu_ctl (in.alu_ctl),
    .done    (done),
    .pass    (pass)
  );

  assign pass_done.done = done;
  assign pass_done.pass = pass;

endmodule

// File: tb/tb_mips_alu.sv
// Directed bench for mips_alu: combinational vector table plus pass/done sequences.
module tb_mips_alu;
  import mips_core_pkg::*;

  typedef struct {
    string            name;
    logic             valid;
    alu_ctl_t         ctl;
    logic [31:0]      op1;
    logic [31:0]      op2;
    logic [31:0]      exp_result;
    logic             exp_taken;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[$];

  alu_input_ifc  in_if ();
  alu_output_ifc out_if ();
  pass_done_ifc  pd_if ();

  mips_alu #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in_if),
    .out       (out_if),
    .pass_done (pd_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input alu_ctl_t c, input logic [31:0] a, input logic [31:0] b);
    in_if.valid   = v;
    in_if.alu_ctl = c;
    in_if.op1     = a;
    in_if.op2     = b;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string name, input logic exp_done, input logic exp_pass);
    chk({name, ".done"}, 32'(pd_if.done), 32'(exp_done));
    chk({name, ".pass"}, 32'(pd_if.pass), 32'(exp_pass));
  endtask

  task automatic add_vec(input string n, input logic v, input alu_ctl_t c, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] r, input logic t);
    vec_t x;
    x.name = n; x.valid = v; x.ctl = c; x.op1 = a; x.op2 = b;
    x.exp_result = r; x.exp_taken = t;
    vecs.push_back(x);
  endtask

  initial begin
    alu_ctl_t undef_ctl;
    undef_ctl = alu_ctl_t'(5'd27);

    add_vec("add_ovf",   1, ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0);
    add_vec("addu_wrap", 1, ADDU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 0);
    add_vec("sub_neg",   1, SUB,  32'd5,         32'd7,         32'hFFFF_FFFE, 0);
    add_vec("subu_wrap", 1, SUBU, 32'd0,         32'd1,         32'hFFFF_FFFF, 0);
    add_vec("and",       1, AND,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 0);
    add_vec("or",        1, OR,   32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF, 0);
    add_vec("xor",       1, XOR,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0, 0);
    add_vec("nor",       1, NOR,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h000F_F000, 0);
    add_vec("slt",       1, SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 0);
    add_vec("sltu",      1, SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 0);
    add_vec("sll",       1, SLL,  32'd4,         32'h0000_0001, 32'h0000_0010, 0);
    add_vec("sll_hi",    1, SLL,  32'hFFFF_FFE4, 32'h0000_0001, 32'h0000_0010, 0);
    add_vec("sra",       1, SRA,  32'd4,         32'h8000_0000, 32'hF800_0000, 0);
    add_vec("srl",       1, SRL,  32'd4,         32'h8000_0000, 32'h0800_0000, 0);
    add_vec("sra_31",    1, SRA,  32'd31,        32'h8000_0000, 32'hFFFF_FFFF, 0);
    add_vec("nop",       1, NOP,  32'd5,         32'd6,         32'h0,         0);
    add_vec("ba",        1, BA,   32'd5,         32'd6,         32'h0,         1);
    add_vec("beq_eq",    1, BEQ,  32'd5,         32'd5,         32'h0,         1);
    add_vec("beq_ne",    1, BEQ,  32'd5,         32'd6,         32'h0,         0);
    add_vec("bne_ne",    1, BNE,  32'd5,         32'd6,         32'h0,         1);
    add_vec("bne_eq",    1, BNE,  32'd5,         32'd5,         32'h0,         0);
    add_vec("blez_0",    1, BLEZ, 32'd0,         32'd9,         32'h0,         1);
    add_vec("blez_pos",  1, BLEZ, 32'd1,         32'd0,         32'h0,         0);
    add_vec("bgtz_0",    1, BGTZ, 32'd0,         32'd9,         32'h0,         0);
    add_vec("bgtz_pos",  1, BGTZ, 32'd1,         32'hFFFF_FFFF, 32'h0,         1);
    add_vec("bgez_neg",  1, BGEZ, 32'hFFFF_FFFF, 32'd0,         32'h0,         0);
    add_vec("bgez_0",    1, BGEZ, 32'd0,         32'd0,         32'h0,         1);
    add_vec("bltz_min",  1, BLTZ, 32'h8000_0000, 32'd0,         32'h0,         1);
    add_vec("bltz_0",    1, BLTZ, 32'd0,         32'd0,         32'h0,         0);
    add_vec("inv_ba",    0, BA,   32'd5,         32'd6,         32'h0,         0);
    add_vec("inv_add",   0, ADD,  32'd2,         32'd3,         32'h0,         0);
    add_vec("mtc0_noop", 1, MTC0_NOOP, 32'd1,    32'd2,         32'h0,         0);
    add_vec("undef",     1, undef_ctl, 32'hFFFF_FFFF, 32'd1,    32'h0,         0);

    // Reset state
    drive(0, NOP, 32'd0, 32'd0);
    rst_n = 1'b0;
    #12;
    chk_flags("reset", 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Combinational vector table, applied mid-cycle
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].valid, vecs[i].ctl, vecs[i].op1, vecs[i].op2);
      #1;
      chk({vecs[i].name, ".valid"},  32'(out_if.valid), 32'(vecs[i].valid));
      chk({vecs[i].name, ".result"}, out_if.result, vecs[i].exp_result);
      chk({vecs[i].name, ".branch"}, 32'(out_if.branch_outcome), 32'(vecs[i].exp_taken));
    end
    edge1();
    chk_flags("after_table", 0, 0);

    // Invalid MTC0_PASS does nothing
    @(negedge clk);
    drive(0, MTC0_PASS, 32'd0, 32'd0);
    edge1();
    edge1();
    chk_flags("inv_pass", 0, 0);

    // Valid MTC0_PASS: flags update on the next edge only, held op acts once
    @(negedge clk);
    drive(1, MTC0_PASS, 32'd0, 32'd0);
    #1;
    chk_flags("pass_pre_edge", 0, 0);
    edge1();
    chk_flags("pass_edge", 1, 1);
    edge1();
    edge1();
    chk_flags("pass_held", 1, 1);

    // Async reset clears flags without a clock edge
    @(negedge clk);
    drive(0, NOP, 32'd0, 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk_flags("async_rst", 0, 0);
    // Combinational path keeps working while in reset
    drive(1, ADD, 32'd2, 32'd3);
    #1;
    chk("rst_comb.result", out_if.result, 32'd5);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, NOP, 32'd0, 32'd0);

    // FAIL then PASS: first outcome sticks
    @(negedge clk);
    drive(1, MTC0_FAIL, 32'd0, 32'd0);
    edge1();
    chk_flags("fail", 1, 0);
    @(negedge clk);
    drive(0, NOP, 32'd0, 32'd0);
    @(negedge clk);
    drive(1, MTC0_PASS, 32'd0, 32'd0);
    edge1();
    edge1();
    chk_flags("fail_then_pass", 1, 0);

    // Reset pulse mid-cycle, then DONE alone keeps pass low and blocks later PASS
    @(negedge clk);
    drive(0, NOP, 32'd0, 32'd0);
    rst_n = 1'b0;
    #1;
    chk_flags("rst_pulse", 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    drive(1, MTC0_DONE, 32'd0, 32'd0);
    edge1();
    chk_flags("done_only", 1, 0);
    @(negedge clk);
    drive(1, MTC0_PASS, 32'd0, 32'd0);
    edge1();
    chk_flags("done_then_pass", 1, 0);

    // NOOP and undefined codes never touch the flags
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    drive(1, MTC0_NOOP, 32'd0, 32'd0);
    edge1();
    @(negedge clk);
    drive(1, undef_ctl, 32'd0, 32'd0);
    edge1();
    chk_flags("noop_undef", 0, 0);

    // PASS after reset from a clean state
    @(negedge clk);
    drive(1, MTC0_PASS, 32'd0, 32'd0);
    edge1();
    chk_flags("pass_after_rst", 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_alu.md
MIPS_ALU -- requirements
Module: mips_alu

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 SHALL have port clk  input  1  clock; all sequential logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in  input  alu_input_ifc  bundle: valid (1), alu_ctl (alu_ctl_t), op1 (DATA_WIDTH), op2 (DATA_WIDTH).
REQ-005 SHALL have port out  output  alu_output_ifc  bundle: valid (1), result (DATA_WIDTH), branch_outcome (branch_outcome_t: NOT_TAKEN=0, TAKEN=1).
REQ-006 SHALL have port pass_done  output  pass_done_ifc  bundle: done (1), pass (1); test-completion flags.

Function
REQ-007 out.valid, out.result and out.branch_outcome SHALL be purely combinational from in (zero-cycle latency, EX-stage same-cycle).
REQ-008 out.valid SHALL equal in.valid.
REQ-009 When in.valid=0: result=0, branch_outcome=NOT_TAKEN, pass_done state unchanged.
REQ-010 Defaults for every valid op: result=0, branch_outcome=NOT_TAKEN unless the op states otherwise.
REQ-011 NOP: result=0.
REQ-012 ADD and ADDU: result=op1+op2 modulo 2^DATA_WIDTH; no overflow trap or flag.
REQ-013 SUB and SUBU: result=op1-op2 modulo 2^DATA_WIDTH; no overflow trap.
REQ-014 AND, OR, XOR, NOR: bitwise; NOR = ~(op1|op2).
REQ-015 SLT: result=1 if signed(op1)<signed(op2), else 0; SLTU: same, unsigned.
REQ-016 SLL: result=op2<<op1[4:0]; SRL: logical right shift of op2 by op1[4:0]; SRA: arithmetic right shift of op2 by op1[4:0]; op1[31:5] ignored.
REQ-017 BA: branch_outcome=TAKEN.
REQ-018 BEQ: TAKEN iff op1==op2; BNE: TAKEN iff op1!=op2.
REQ-019 BLEZ, BGTZ, BGEZ, BLTZ: TAKEN iff signed(op1) <=0, >0, >=0, <0 respectively; op2 ignored.
REQ-020 Branch ops SHALL drive result=0.
REQ-021 MTC0_NOOP: no effect.
REQ-022 MTC0_PASS (valid): done<=1, pass<=1 at next clk edge.
REQ-023 MTC0_FAIL (valid): done<=1, pass<=0 at next clk edge.
REQ-024 MTC0_DONE (valid): done<=1, pass unchanged.
REQ-025 pass_done SHALL be registered and sticky: once done=1, later MTC0 ops SHALL NOT change done or pass until reset (first outcome wins).
REQ-026 An in.valid MTC0 op held for multiple cycles SHALL behave as a single occurrence.
REQ-027 Unlisted/undefined alu_ctl codes SHALL produce result=0, NOT_TAKEN, no pass_done change.

Reset
REQ-028 rst_n low SHALL asynchronously force pass_done.done=0 and pass_done.pass=0.
REQ-029 Combinational outputs SHALL follow in during reset; reset asserted mid-test SHALL clear a latched done/pass immediately.

Structure
REQ-030 alu_ctl_t (NOP, ADD, ADDU, SUB, SUBU, AND, OR, XOR, NOR, SLL, SRL, SRA, SLT, SLTU, MTC0_NOOP, MTC0_PASS, MTC0_FAIL, MTC0_DONE, BA, BEQ, BNE, BLEZ, BGTZ, BGEZ, BLTZ), branch_outcome_t and DATA_WIDTH SHALL reside in the shared core package mips_core_pkg.
REQ-031 alu_input_ifc, alu_output_ifc, pass_done_ifc SHALL be interfaces with in/out modports.
REQ-032 One sub-module is natural: mips_alu_pass_done_reg (sticky done/pass flops); the datapath SHALL be a single combinational case block.

Verification
REQ-033 valid=1, ADD, op1=0x7FFFFFFF, op2=1 -> result=0x80000000, NOT_TAKEN, same cycle; ADDU 0xFFFFFFFF+1 -> 0.
REQ-034 SLT op1=0xFFFFFFFF, op2=1 -> result=1; SLTU same operands -> result=0; SRA op2=0x80000000, op1=4 -> 0xF8000000; SRL -> 0x08000000.
REQ-035 BEQ op1=op2=5 -> TAKEN, result=0; BLEZ op1=0 -> TAKEN; BGTZ op1=0 -> NOT_TAKEN; BLTZ op1=0x80000000 -> TAKEN.
REQ-036 valid=0 with BA -> out.valid=0, result=0, NOT_TAKEN.
REQ-037 MTC0_FAIL then MTC0_PASS on later cycle -> done=1, pass=0 stays; rst_n pulse low -> done=0, pass=0 without clock edge.
REQ-038 After reset, MTC0_PASS -> done=1, pass=1 one edge later; invalid MTC0_PASS -> no change.
